// File: rtl/uart_cmd_master.sv
// UART command master: fetches 32-bit command words from the UART word engine,
// runs them against the register port and sends back one 32-bit reply word.
module uart_cmd_master #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] DEVICE_ID  = 32'h50494E47,
    parameter logic [31:0] ACK_WORD   = 32'h41434B21,
    parameter logic [31:0] NAK_WORD   = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  uart_rx_empty,
    output logic                  read,
    input  logic                  read_response,
    input  logic [31:0]           read_data,
    output logic                  write,
    output logic [31:0]           write_data,
    input  logic                  write_response,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [31:0]           reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [31:0]           reg_rdata,
    output logic                  busy,
    output logic [15:0]           cmd_count,
    output logic [15:0]           err_count
);

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        DECODE,
        REG_RD,
        RD_ARG,
        WR_REQ,
        WR_WAIT,
        WR_DRAIN
    } state_t;

    localparam logic [7:0] OP_PING  = 8'h70;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;

    state_t                state;
    logic [7:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]           resp;

    logic is_ping;
    logic is_read;
    logic is_write;

    assign is_ping  = (cmd_op == OP_PING);
    assign is_read  = (cmd_op == OP_READ);
    assign is_write = (cmd_op == OP_WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            read       <= 1'b0;
            write      <= 1'b0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            busy       <= 1'b0;
            write_data <= '0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            cmd_count  <= '0;
            err_count  <= '0;
            cmd_op     <= '0;
            cmd_addr   <= '0;
            resp       <= '0;
        end else begin
            read   <= 1'b0;
            write  <= 1'b0;
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable && !uart_rx_empty) begin
                        read  <= 1'b1;
                        busy  <= 1'b1;
                        state <= RD_CMD;
                    end
                end
                RD_CMD: begin
                    if (read_response) begin
                        cmd_op   <= read_data[31:24];
                        cmd_addr <= read_data[ADDR_WIDTH-1:0];
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    unique case (1'b1)
                        is_ping: begin
                            resp  <= DEVICE_ID;
                            state <= WR_REQ;
                        end
                        is_read: begin
                            reg_addr <= cmd_addr;
                            reg_re   <= 1'b1;
                            state    <= REG_RD;
                        end
                        is_write: begin
                            reg_addr <= cmd_addr;
                            read     <= 1'b1;
                            state    <= RD_ARG;
                        end
                        default: begin
                            resp      <= NAK_WORD;
                            err_count <= err_count + 16'd1;
                            state     <= WR_REQ;
                        end
                    endcase
                end
                REG_RD: begin
                    resp  <= reg_rdata;
                    state <= WR_REQ;
                end
                RD_ARG: begin
                    if (read_response) begin
                        reg_wdata <= read_data;
                        reg_we    <= 1'b1;
                        resp      <= ACK_WORD;
                        state     <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    write_data <= resp;
                    write      <= 1'b1;
                    state      <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (write_response) begin
                        state <= WR_DRAIN;
                    end
                end
                // a repeated write_response lands here and is swallowed
                WR_DRAIN: begin
                    cmd_count <= cmd_count + 16'd1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Bench for uart_cmd_master: UART engine and register bank models plus a
// command-level reference model driving directed and random commands.
module tb_uart_cmd_master;

    localparam logic [31:0] DEV = 32'h50494E47;
    localparam logic [31:0] ACK = 32'h41434B21;
    localparam logic [31:0] NAK = 32'hFFFFFFFF;
    localparam int          NO_HOLD = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        uart_rx_empty = 1'b1;
    logic        read;
    logic        read_response = 1'b0;
    logic [31:0] read_data = '0;
    logic        write;
    logic [31:0] write_data;
    logic        write_response = 1'b0;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;
    logic        busy;
    logic [15:0] cmd_count;
    logic [15:0] err_count;

    uart_cmd_master dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .uart_rx_empty  (uart_rx_empty),
        .read           (read),
        .read_response  (read_response),
        .read_data      (read_data),
        .write          (write),
        .write_data     (write_data),
        .write_response (write_response),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_we         (reg_we),
        .reg_re         (reg_re),
        .reg_rdata      (reg_rdata),
        .busy           (busy),
        .cmd_count      (cmd_count),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] rx_q[$];
    logic [31:0] got_q[$];
    logic [39:0] we_q[$];
    logic [7:0]  re_q[$];

    int cyc = 0;
    int rd_pulses = 0;
    int last_rr_cyc = 0;
    int wr_cyc = 0;
    int wr_idx = 0;
    int hold_from = NO_HOLD;
    int stab_err = 0;
    bit dbl_next = 0;

    bit          rd_pend = 0;
    int          rd_dly = 0;
    bit          wr_pend = 0;
    int          wr_dly = 0;
    bit          wr_dbl = 0;
    bit          wr_second = 0;
    logic [31:0] wr_hold_data = '0;

    logic [31:0] mem[256];
    logic [31:0] ref_mem[256];
    bit          mem_init = 0;
    int          exp_cmd = 0;
    int          exp_err = 0;

    function automatic logic [31:0] init_word(int a);
        if (a == 5) return 32'hDEADBEEF;
        return 32'(32'h9E3779B9 * (a + 1));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always_comb reg_rdata = mem[reg_addr];

    // UART engine, register bank and strobe monitor, all acting at negedge
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = init_word(i);
            mem_init = 1;
        end
        read_response = 1'b0;
        if (read) begin
            rd_pend = 1;
            rd_dly = $urandom_range(0, 2);
            rd_pulses++;
        end
        if (rd_pend) begin
            if (rd_dly == 0 && rx_q.size() > 0) begin
                read_response = 1'b1;
                read_data = rx_q.pop_front();
                rd_pend = 0;
                last_rr_cyc = cyc;
            end else if (rd_dly > 0) begin
                rd_dly--;
            end
        end
        write_response = 1'b0;
        if (wr_second) begin
            write_response = 1'b1;
            wr_second = 0;
        end
        if (write) begin
            got_q.push_back(write_data);
            wr_cyc = cyc;
            wr_idx++;
            wr_pend = 1;
            wr_dly = $urandom_range(0, 2);
            wr_hold_data = write_data;
            wr_dbl = dbl_next;
            dbl_next = 0;
        end else if (wr_pend && !rst && busy && write_data !== wr_hold_data) begin
            stab_err++;
        end
        if (wr_pend && wr_idx < hold_from) begin
            if (wr_dly == 0) begin
                write_response = 1'b1;
                wr_pend = 0;
                if (wr_dbl) wr_second = 1;
            end else begin
                wr_dly--;
            end
        end
        if (reg_we) begin
            we_q.push_back({reg_addr, reg_wdata});
            mem[reg_addr] = reg_wdata;
        end
        if (reg_re) re_q.push_back(reg_addr);
        uart_rx_empty = (rx_q.size() == 0);
    end

    task automatic wait_done(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (got_q.size() >= target && !busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic do_cmd(input logic [31:0] c, input logic [31:0] arg,
                          input bit has_arg, output logic [31:0] reply,
                          output bit ok);
        int t;
        t = got_q.size() + 1;
        rx_q.push_back(c);
        if (has_arg) rx_q.push_back(arg);
        wait_done(t, ok);
        reply = ok ? got_q[t-1] : 32'hx;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({read, write, reg_we, reg_re, busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=00000",
                     {read, write, reg_we, reg_re, busy});
        end
        total++;
        if (write_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_write_data got=%h want=0", write_data);
        end
        total++;
        if ({reg_addr, reg_wdata} !== 40'h0) begin
            bad++;
            $display("FAIL reset_reg_bus got=%h want=0", {reg_addr, reg_wdata});
        end
        total++;
        if ({cmd_count, err_count} !== 32'h0) begin
            bad++;
            $display("FAIL reset_counts got=%h want=0", {cmd_count, err_count});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ping();
        logic [31:0] r;
        bit ok;
        int re0, we0;
        re0 = re_q.size();
        we0 = we_q.size();
        do_cmd(32'h70000000, 32'h0, 0, r, ok);
        exp_cmd++;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ping_timeout got=busy want=done");
        end
        total++;
        if (r !== DEV) begin
            bad++;
            $display("FAIL ping_reply got=%h want=%h", r, DEV);
        end
        total++;
        if (wr_cyc - last_rr_cyc !== 3) begin
            bad++;
            $display("FAIL ping_latency got=%0d want=3", wr_cyc - last_rr_cyc);
        end
        total++;
        if (cmd_count !== 16'(exp_cmd)) begin
            bad++;
            $display("FAIL ping_cmd_count got=%0d want=%0d", cmd_count, exp_cmd);
        end
        total++;
        if (re_q.size() != re0 || we_q.size() != we0) begin
            bad++;
            $display("FAIL ping_strobes got=%0d/%0d want=%0d/%0d",
                     re_q.size(), we_q.size(), re0, we0);
        end
    endtask

    task automatic test_read();
        logic [31:0] r;
        bit ok;
        int re0;
        re0 = re_q.size();
        do_cmd(32'h52000005, 32'h0, 0, r, ok);
        exp_cmd++;
        total++;
        if (re_q.size() != re0 + 1 || re_q[re_q.size()-1] !== 8'h05) begin
            bad++;
            $display("FAIL read_strobe got=%0d@%h want=1@05",
                     re_q.size() - re0, re_q[re_q.size()-1]);
        end
        total++;
        if (r !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL read_reply got=%h want=deadbeef", r);
        end
        total++;
        if (cmd_count !== 16'(exp_cmd)) begin
            bad++;
            $display("FAIL read_cmd_count got=%0d want=%0d", cmd_count, exp_cmd);
        end
    endtask

    task automatic test_write();
        logic [31:0] r;
        bit ok;
        int we0;
        we0 = we_q.size();
        do_cmd(32'h57000010, 32'h12345678, 1, r, ok);
        exp_cmd++;
        ref_mem[8'h10] = 32'h12345678;
        total++;
        if (we_q.size() != we0 + 1) begin
            bad++;
            $display("FAIL write_we_count got=%0d want=1", we_q.size() - we0);
        end
        total++;
        if (we_q[we_q.size()-1] !== {8'h10, 32'h12345678}) begin
            bad++;
            $display("FAIL write_we_bus got=%h want=1012345678",
                     we_q[we_q.size()-1]);
        end
        total++;
        if (r !== ACK) begin
            bad++;
            $display("FAIL write_reply got=%h want=%h", r, ACK);
        end
    endtask

    task automatic test_unknown();
        logic [31:0] r;
        bit ok;
        int re0, we0;
        re0 = re_q.size();
        we0 = we_q.size();
        do_cmd(32'hAA000000, 32'h0, 0, r, ok);
        exp_cmd++;
        exp_err++;
        total++;
        if (r !== NAK) begin
            bad++;
            $display("FAIL unknown_reply got=%h want=%h", r, NAK);
        end
        total++;
        if (err_count !== 16'(exp_err) || cmd_count !== 16'(exp_cmd)) begin
            bad++;
            $display("FAIL unknown_counts got=%0d/%0d want=%0d/%0d",
                     err_count, cmd_count, exp_err, exp_cmd);
        end
        total++;
        if (re_q.size() != re0 || we_q.size() != we0) begin
            bad++;
            $display("FAIL unknown_strobes got=%0d/%0d want=0/0",
                     re_q.size() - re0, we_q.size() - we0);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        bit ok;
        t = got_q.size();
        hold_from = wr_idx + 2;
        dbl_next = 1;
        rx_q.push_back(32'h70000000);
        rx_q.push_back(32'h70000000);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (got_q.size() >= t + 2) begin
                ok = 1;
                break;
            end
        end
        exp_cmd++;
        repeat (8) @(negedge clk);
        total++;
        if (!ok || cmd_count !== 16'(exp_cmd) || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_held got=%0d busy=%b want=%0d busy=1",
                     cmd_count, busy, exp_cmd);
        end
        hold_from = NO_HOLD;
        wait_done(t + 2, ok);
        exp_cmd++;
        total++;
        if (!ok || cmd_count !== 16'(exp_cmd)) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=%0d", cmd_count, exp_cmd);
        end
        total++;
        if (got_q.size() != t + 2 || got_q[t] !== DEV || got_q[t+1] !== DEV) begin
            bad++;
            $display("FAIL b2b_replies got=%0d want=2", got_q.size() - t);
        end
    endtask

    task automatic test_enable();
        int p0;
        logic [31:0] r;
        bit ok;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        p0 = rd_pulses;
        rx_q.push_back(32'h70000000);
        repeat (10) @(negedge clk);
        total++;
        if (rd_pulses != p0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL enable_low got=%0d busy=%b want=0 busy=0",
                     rd_pulses - p0, busy);
        end
        enable = 1'b1;
        wait_done(got_q.size() + 1, ok);
        r = got_q[got_q.size()-1];
        exp_cmd++;
        total++;
        if (!ok || r !== DEV || cmd_count !== 16'(exp_cmd)) begin
            bad++;
            $display("FAIL enable_resume got=%h/%0d want=%h/%0d",
                     r, cmd_count, DEV, exp_cmd);
        end
    endtask

    task automatic test_reset_mid();
        int t, p0;
        bit ok;
        logic [31:0] r;
        t = got_q.size();
        hold_from = wr_idx + 1;
        rx_q.push_back(32'h70000000);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (got_q.size() > t) begin
                ok = 1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        total++;
        if (!ok || busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_wait got=%b want=1", busy);
        end
        #2 rst = 1'b1;
        #1;
        exp_cmd = 0;
        exp_err = 0;
        total++;
        if (busy !== 1'b0 || write_data !== 32'h0) begin
            bad++;
            $display("FAIL midrst_clear got=%b/%h want=0/0", busy, write_data);
        end
        total++;
        if (cmd_count !== 16'h0 || err_count !== 16'h0) begin
            bad++;
            $display("FAIL midrst_counts got=%0d/%0d want=0/0",
                     cmd_count, err_count);
        end
        enable = 1'b0;
        @(negedge clk);
        hold_from = NO_HOLD;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        p0 = rd_pulses;
        rx_q.push_back(32'h70000000);
        repeat (10) @(negedge clk);
        total++;
        if (busy !== 1'b0 || rd_pulses != p0 || cmd_count !== 16'h0) begin
            bad++;
            $display("FAIL midrst_idle got=%b/%0d/%0d want=0/0/0",
                     busy, rd_pulses - p0, cmd_count);
        end
        enable = 1'b1;
        wait_done(got_q.size() + 1, ok);
        r = got_q[got_q.size()-1];
        exp_cmd = 1;
        total++;
        if (!ok || r !== DEV || cmd_count !== 16'd1) begin
            bad++;
            $display("FAIL midrst_after got=%h/%0d want=%h/1", r, cmd_count, DEV);
        end
    endtask

    task automatic test_random();
        logic [31:0] c, arg, exp, r;
        logic [7:0] op, addr;
        bit ok, has_arg;
        int we0;
        for (int n = 0; n < 40; n++) begin
            addr = 8'($urandom_range(0, 255));
            arg = $urandom;
            has_arg = 0;
            dbl_next = bit'($urandom_range(0, 1));
            we0 = we_q.size();
            case ($urandom_range(0, 3))
                0: begin
                    c = {8'h70, 24'($urandom)};
                    exp = DEV;
                end
                1: begin
                    c = {8'h52, 16'($urandom), addr};
                    exp = ref_mem[addr];
                end
                2: begin
                    c = {8'h57, 16'($urandom), addr};
                    has_arg = 1;
                    exp = ACK;
                    ref_mem[addr] = arg;
                end
                default: begin
                    do op = 8'($urandom_range(0, 255));
                    while (op == 8'h70 || op == 8'h52 || op == 8'h57);
                    c = {op, 24'($urandom)};
                    exp = NAK;
                    exp_err++;
                end
            endcase
            exp_cmd++;
            do_cmd(c, arg, has_arg, r, ok);
            total++;
            if (!ok || r !== exp) begin
                bad++;
                $display("FAIL rand_reply n=%0d cmd=%h got=%h want=%h",
                         n, c, r, exp);
            end
            total++;
            if (cmd_count !== 16'(exp_cmd) || err_count !== 16'(exp_err)) begin
                bad++;
                $display("FAIL rand_counts n=%0d got=%0d/%0d want=%0d/%0d",
                         n, cmd_count, err_count, exp_cmd, exp_err);
            end
            if (has_arg) begin
                total++;
                if (we_q.size() != we0 + 1 ||
                    we_q[we_q.size()-1] !== {addr, arg}) begin
                    bad++;
                    $display("FAIL rand_we n=%0d got=%h want=%h",
                             n, we_q[we_q.size()-1], {addr, arg});
                end
            end
        end
        total++;
        if (stab_err != 0) begin
            bad++;
            $display("FAIL write_data_stable got=%0d want=0", stab_err);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_ping();
        test_read();
        test_write();
        test_unknown();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
